alarm_clock_core: RTL and testbench

Hardware timekeeping core that replaces the software clock loop on the soft CPU. Keeps 24-hour time in BCD, supports NUM_ALARMS independently editable alarms, 24h/12h display modes and button-driven editing. Drives the six seven-segment digits directly from the board switches and debounced edit buttons.

---
 rtl/alarm_clock_pkg.sv | 75 +++++++
 rtl/alarm_clock_core_seg7_encode.sv | 39 +++
 rtl/alarm_clock_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alarm_clock_core.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alarm_clock_pkg : shared types, segment patterns and BCD helpers    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package alarm_clock_pkg;

   typedef enum logic [1:0] {
      RUN24      = 2'b00,
      EDIT_TIME  = 2'b01,
      EDIT_ALARM = 2'b10,
      RUN12      = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      HOUR = 2'd0,
      MIN  = 2'd1,
      SEC  = 2'd2
   } field_e;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
   } alarm_t;

   localparam logic [7:0] c_max_hour = 8'h23;
   localparam logic [7:0] c_max_min  = 8'h59;
   localparam logic [7:0] c_max_sec  = 8'h59;

   // Active-high patterns, bit order gfedcba
   localparam logic [6:0] c_seg_0     = 7'b0111111;
   localparam logic [6:0] c_seg_1     = 7'b0000110;
   localparam logic [6:0] c_seg_2     = 7'b1011011;
   localparam logic [6:0] c_seg_3     = 7'b1001111;
   localparam logic [6:0] c_seg_4     = 7'b1100110;
   localparam logic [6:0] c_seg_5     = 7'b1101101;
   localparam logic [6:0] c_seg_6     = 7'b1111101;
   localparam logic [6:0] c_seg_7     = 7'b0000111;
   localparam logic [6:0] c_seg_8     = 7'b1111111;
   localparam logic [6:0] c_seg_9     = 7'b1101111;
   localparam logic [6:0] c_seg_blank = 7'b0000000;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v) begin
         return 8'h00;
      end
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // 24h BCD hour to 12h BCD hour: 0 -> 12, 13..23 -> 1..11
   function automatic logic [7:0] to_12h(input logic [7:0] h);
      logic [4:0] b;
      logic [3:0] tens;
      logic [3:0] units;
      b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
      if (b == 5'd0) begin
         b = 5'd12;
      end else if (b > 5'd12) begin
         b = b - 5'd12;
      end
      if (b >= 5'd10) begin
         tens  = 4'd1;
         units = 4'(b - 5'd10);
      end else begin
         tens  = 4'd0;
         units = 4'(b);
      end
      return {tens, units};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_clock_core_seg7_encode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_encode : BCD digit plus blank to seven segments (gfedcba)      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module seg7_encode
   import alarm_clock_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   logic [6:0] pattern;

   always_comb begin
      pattern = c_seg_blank;
      if (!blank) begin
         case (bcd)
            4'd0:    pattern = c_seg_0;
            4'd1:    pattern = c_seg_1;
            4'd2:    pattern = c_seg_2;
            4'd3:    pattern = c_seg_3;
            4'd4:    pattern = c_seg_4;
            4'd5:    pattern = c_seg_5;
            4'd6:    pattern = c_seg_6;
            4'd7:    pattern = c_seg_7;
            4'd8:    pattern = c_seg_8;
            4'd9:    pattern = c_seg_9;
            default: pattern = c_seg_blank;
         endcase
      end
      seg = SEG_ACTIVE_LOW ? ~pattern : pattern;
   end

endmodule
`default_nettype wire

// File: rtl/alarm_clock_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alarm_clock_core : BCD time-of-day, alarms, editing, 7-seg display  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module alarm_clock_core
   import alarm_clock_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int TICK_DIV       = 50_000_000,
   parameter int NUM_ALARMS     = 1,
   parameter int RING_SECONDS   = 60,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   localparam int AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    sw_states,
   input  logic [1:0]    btn_edit,
   input  logic [AW-1:0] alarm_sel,
   output logic [6:0]    led_seconds_units,
   output logic [6:0]    led_seconds_tens,
   output logic [6:0]    led_minutes_units,
   output logic [6:0]    led_minutes_tens,
   output logic [6:0]    led_hour_units,
   output logic [6:0]    led_hour_tens,
   output logic          alarm_ring,
   output logic          tick_1hz
);

   localparam int              PW          = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   c_presc_max = PW'(TICK_DIV - 1);
   localparam logic [7:0]      c_ring_load = 8'(RING_SECONDS);

   generate
      if (TICK_DIV < 2 || NUM_ALARMS < 1 || NUM_ALARMS > 4 ||
          RING_SECONDS < 1 || RING_SECONDS > 255 || CLK_HZ < 1) begin : g_param_check
         $error("alarm_clock_core: parameter out of range");
      end
   endgenerate

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   alarm_t        alarm_q [NUM_ALARMS];
   alarm_t        alarm_d [NUM_ALARMS];
   field_e        field_q, field_d;
   logic [1:0]    btn_prev_q, btn_prev_d;
   mode_e         mode_prev_q, mode_prev_d;
   logic          tick_pend_q, tick_pend_d;
   logic          tick_1hz_q, tick_1hz_d;
   logic          ring_q, ring_d;
   logic [7:0]    ring_cnt_q, ring_cnt_d;
   logic [6:0]    seg_q [6];
   logic [6:0]    seg_enc [6];

   mode_e         mode;
   logic          mode_changed;
   logic          edit_time;
   logic          edit_alarm;
   logic          run_mode;
   logic [1:0]    btn_edge;
   field_e        field_eff;
   logic          advance;
   logic [AW-1:0] sel_idx;
   alarm_t        shown_alarm;
   logic          alarm_hit;
   logic          match_ok;
   logic          cancel;
   logic [7:0]    disp_hh, disp_mm, disp_ss, hh_show;
   logic [3:0]    digit [6];
   logic          digit_blank [6];

   always_comb begin
      mode         = mode_e'(sw_states[1:0]);
      mode_prev_d  = mode;
      mode_changed = (mode != mode_prev_q);
      edit_time    = (mode == EDIT_TIME);
      edit_alarm   = (mode == EDIT_ALARM);
      run_mode     = !edit_time && !edit_alarm;
      btn_edge     = btn_edit & ~btn_prev_q;
      btn_prev_d   = btn_edit;
      field_eff    = mode_changed ? HOUR : field_q;
      sel_idx      = (int'(alarm_sel) < NUM_ALARMS) ? alarm_sel : '0;
      advance      = (presc_q == c_presc_max) && !edit_time;
   end

   // Any mode change restarts the second so a run mode starts on a full period
   always_comb begin
      if (mode_changed || edit_time || presc_q == c_presc_max) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_comb begin
      field_d = field_q;
      if (mode_changed) begin
         field_d = HOUR;
      end else if (btn_edge[0]) begin
         if (edit_time) begin
            case (field_q)
               HOUR:    field_d = MIN;
               MIN:     field_d = SEC;
               default: field_d = HOUR;
            endcase
         end else if (edit_alarm) begin
            field_d = (field_q == HOUR) ? MIN : HOUR;
         end
      end
   end

   always_comb begin
      hh_d = hh_q;
      mm_d = mm_q;
      ss_d = ss_q;
      if (advance) begin
         ss_d = bcd_inc(ss_q, c_max_sec);
         if (ss_q == c_max_sec) begin
            mm_d = bcd_inc(mm_q, c_max_min);
            if (mm_q == c_max_min) begin
               hh_d = bcd_inc(hh_q, c_max_hour);
            end
         end
      end else if (edit_time && btn_edge[1]) begin
         case (field_eff)
            HOUR:    hh_d = bcd_inc(hh_q, c_max_hour);
            MIN:     mm_d = bcd_inc(mm_q, c_max_min);
            default: ss_d = 8'h00;
         endcase
      end
   end

   always_comb begin
      shown_alarm = '0;
      alarm_hit   = 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         alarm_d[k] = alarm_q[k];
         if (k == int'(sel_idx)) begin
            shown_alarm = alarm_q[k];
            if (edit_alarm && btn_edge[1]) begin
               if (field_eff == HOUR) begin
                  alarm_d[k].hh = bcd_inc(alarm_q[k].hh, c_max_hour);
               end else begin
                  alarm_d[k].mm = bcd_inc(alarm_q[k].mm, c_max_min);
               end
            end
         end
         if (alarm_q[k].hh == hh_q && alarm_q[k].mm == mm_q && ss_q == 8'h00) begin
            alarm_hit = 1'b1;
         end
      end
   end

   // tick_pend_q marks the cycle right after the time update, which is when the
   // new time is visible for comparison and tick_1hz/ring outputs are loaded.
   always_comb begin
      tick_pend_d = advance;
      tick_1hz_d  = tick_pend_q;
      match_ok    = tick_pend_q && run_mode && sw_states[2] && alarm_hit;
      cancel      = (|btn_edge) || !sw_states[2] || !run_mode;
      ring_d      = ring_q;
      ring_cnt_d  = ring_cnt_q;
      if (cancel) begin
         ring_d     = 1'b0;
         ring_cnt_d = 8'd0;
      end else if (match_ok) begin
         ring_d     = 1'b1;
         ring_cnt_d = c_ring_load;
      end else if (ring_q && tick_pend_q) begin
         ring_cnt_d = ring_cnt_q - 8'd1;
         if (ring_cnt_q == 8'd1) begin
            ring_d = 1'b0;
         end
      end
   end

   // During reset the display is loaded from the reset time rather than the old one
   always_comb begin
      if (reset) begin
         disp_hh = 8'h00;
         disp_mm = 8'h00;
         disp_ss = 8'h00;
      end else if (edit_alarm) begin
         disp_hh = shown_alarm.hh;
         disp_mm = shown_alarm.mm;
         disp_ss = 8'h00;
      end else begin
         disp_hh = hh_q;
         disp_mm = mm_q;
         disp_ss = ss_q;
      end
      hh_show = (mode == RUN12) ? to_12h(disp_hh) : disp_hh;
      digit[0] = disp_ss[3:0];
      digit[1] = disp_ss[7:4];
      digit[2] = disp_mm[3:0];
      digit[3] = disp_mm[7:4];
      digit[4] = hh_show[3:0];
      digit[5] = hh_show[7:4];
      for (int i = 0; i < 5; i++) begin
         digit_blank[i] = 1'b0;
      end
      digit_blank[5] = (mode == RUN12) && (hh_show[7:4] == 4'd0);
   end

   generate
      for (genvar i = 0; i < 6; i++) begin : g_digit
         seg7_encode #(
            .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
         ) u_seg7_encode (
            .bcd   (digit[i]),
            .blank (digit_blank[i]),
            .seg   (seg_enc[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q     <= '0;
         hh_q        <= 8'h00;
         mm_q        <= 8'h00;
         ss_q        <= 8'h00;
         for (int k = 0; k < NUM_ALARMS; k++) begin
            alarm_q[k] <= '0;
         end
         field_q     <= HOUR;
         btn_prev_q  <= 2'b00;
         tick_pend_q <= 1'b0;
         tick_1hz_q  <= 1'b0;
         ring_q      <= 1'b0;
         ring_cnt_q  <= 8'd0;
      end else begin
         presc_q     <= presc_d;
         hh_q        <= hh_d;
         mm_q        <= mm_d;
         ss_q        <= ss_d;
         for (int k = 0; k < NUM_ALARMS; k++) begin
            alarm_q[k] <= alarm_d[k];
         end
         field_q     <= field_d;
         btn_prev_q  <= btn_prev_d;
         tick_pend_q <= tick_pend_d;
         tick_1hz_q  <= tick_1hz_d;
         ring_q      <= ring_d;
         ring_cnt_q  <= ring_cnt_d;
      end
      mode_prev_q <= mode_prev_d;
      for (int i = 0; i < 6; i++) begin
         seg_q[i] <= seg_enc[i];
      end
   end

   assign led_seconds_units = seg_q[0];
   assign led_seconds_tens  = seg_q[1];
   assign led_minutes_units = seg_q[2];
   assign led_minutes_tens  = seg_q[3];
   assign led_hour_units    = seg_q[4];
   assign led_hour_tens     = seg_q[5];
   assign alarm_ring        = ring_q;
   assign tick_1hz          = tick_1hz_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alarm_clock_core : randomized and directed bench, integer model  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_alarm_clock_core;

   localparam int TICK_DIV = 4;
   localparam int NUM_AL   = 4;
   localparam int RING_S   = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] sw_states;
   logic [1:0] btn_edit;
   logic [1:0] alarm_sel;
   logic [6:0] led_seconds_units, led_seconds_tens, led_minutes_units;
   logic [6:0] led_minutes_tens, led_hour_units, led_hour_tens;
   logic       alarm_ring, tick_1hz;
   logic [41:0] seg_bus;

   int checks   = 0;
   int failures = 0;

   alarm_clock_core #(
      .CLK_HZ         (1000),
      .TICK_DIV       (TICK_DIV),
      .NUM_ALARMS     (NUM_AL),
      .RING_SECONDS   (RING_S),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .sw_states         (sw_states),
      .btn_edit          (btn_edit),
      .alarm_sel         (alarm_sel),
      .led_seconds_units (led_seconds_units),
      .led_seconds_tens  (led_seconds_tens),
      .led_minutes_units (led_minutes_units),
      .led_minutes_tens  (led_minutes_tens),
      .led_hour_units    (led_hour_units),
      .led_hour_tens     (led_hour_tens),
      .alarm_ring        (alarm_ring),
      .tick_1hz          (tick_1hz)
   );

   always #5 clk = ~clk;

   assign seg_bus = {led_hour_tens, led_hour_units, led_minutes_tens,
                     led_minutes_units, led_seconds_tens, led_seconds_units};

   // Reference model: time as seconds of day, alarms as minutes of day
   int          m_tod, m_cnt, m_field, m_left;
   int          m_al [NUM_AL];
   bit          m_pend, m_tick, m_ring;
   logic [1:0]  m_prev_btn, m_prev_mode;
   logic [41:0] m_seg;

   function automatic logic [6:0] seg_of(input int d, input bit blank);
      if (blank) return 7'b1111111;
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [41:0] disp(input int h, input int m, input int s, input bit h12);
      int hh;
      bit bl;
      hh = h;
      bl = 1'b0;
      if (h12) begin
         hh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
         bl = (hh < 10);
      end
      return {seg_of(hh / 10, bl), seg_of(hh % 10, 1'b0), seg_of(m / 10, 1'b0),
              seg_of(m % 10, 1'b0), seg_of(s / 10, 1'b0), seg_of(s % 10, 1'b0)};
   endfunction

   task automatic model_step();
      logic [1:0] md, eb;
      bit chg, en, run, any, adv;
      int f, idx, h, m, s;
      md  = sw_states[1:0];
      en  = sw_states[2];
      chg = (md != m_prev_mode);
      eb  = btn_edit & ~m_prev_btn;
      run = (md == 2'b00) || (md == 2'b11);
      idx = (int'(alarm_sel) < NUM_AL) ? int'(alarm_sel) : 0;
      if (md == 2'b10) m_seg = disp(m_al[idx] / 60, m_al[idx] % 60, 0, 1'b0);
      else m_seg = disp(m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, md == 2'b11);
      m_tick = m_pend;
      any = 1'b0;
      for (int k = 0; k < NUM_AL; k++) if (m_al[k] * 60 == m_tod) any = 1'b1;
      if (eb != 2'b00 || !en || !run) m_ring = 1'b0;
      else if (m_pend && any) begin
         m_ring = 1'b1;
         m_left = RING_S;
      end else if (m_ring && m_pend) begin
         m_left--;
         if (m_left == 0) m_ring = 1'b0;
      end
      adv    = (m_cnt == TICK_DIV - 1) && (md != 2'b01);
      m_cnt  = (chg || md == 2'b01) ? 0 : (m_cnt + 1) % TICK_DIV;
      m_pend = adv;
      f = chg ? 0 : m_field;
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      if (adv) m_tod = (m_tod + 1) % 86400;
      else if (md == 2'b01 && eb[1]) begin
         if (f == 0) h = (h + 1) % 24;
         else if (f == 1) m = (m + 1) % 60;
         else s = 0;
         m_tod = h * 3600 + m * 60 + s;
      end
      if (md == 2'b10 && eb[1]) begin
         if (f == 0) m_al[idx] = ((m_al[idx] / 60 + 1) % 24) * 60 + m_al[idx] % 60;
         else m_al[idx] = (m_al[idx] / 60) * 60 + (m_al[idx] % 60 + 1) % 60;
      end
      if (chg) m_field = 0;
      else if (eb[0]) begin
         if (md == 2'b01) m_field = (m_field + 1) % 3;
         else if (md == 2'b10) m_field = (m_field == 0) ? 1 : 0;
      end
      m_prev_btn  = btn_edit;
      m_prev_mode = md;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_tod = 0;
      m_cnt = 0;
      m_field = 0;
      m_left = 0;
      for (int k = 0; k < NUM_AL; k++) m_al[k] = 0;
      m_pend = 1'b0;
      m_tick = 1'b0;
      m_ring = 1'b0;
      m_prev_btn  = 2'b00;
      m_prev_mode = sw_states[1:0];
      m_seg = disp(0, 0, 0, sw_states[1:0] == 2'b11);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic press(input int i);
      btn_edit[i] = 1'b1;
      cyc();
      btn_edit = 2'b00;
      cyc();
   endtask

   task automatic set_time(input int h, input int m);
      sw_states[1:0] = 2'b01;
      cyc();
      for (int n = 0; n < 24 && m_tod / 3600 != h; n++) press(1);
      press(0);
      for (int n = 0; n < 60 && (m_tod / 60) % 60 != m; n++) press(1);
      press(0);
      press(1);
   endtask

   task automatic set_alarm(input int k, input int h, input int m);
      sw_states[1:0] = 2'b10;
      alarm_sel = 2'(k);
      cyc();
      for (int n = 0; n < 24 && m_al[k] / 60 != h; n++) press(1);
      press(0);
      for (int n = 0; n < 60 && m_al[k] % 60 != m; n++) press(1);
   endtask

   task automatic wait_ring(input string tag, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 600 && !ok; n++) begin
         cyc();
         checks++;
         if (alarm_ring !== m_ring) begin
            failures++;
            $display("FAIL %s_ring_track got=%b want=%b", tag, alarm_ring, m_ring);
         end
         if (alarm_ring === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_ring_timeout got=no_ring want=ring", tag);
      end
   endtask

   task automatic test_reset();
      sw_states = 3'b000;
      btn_edit  = 2'b00;
      alarm_sel = 2'd0;
      do_reset();
      checks++;
      if (seg_bus !== {6{7'b1000000}}) begin
         failures++;
         $display("FAIL reset_segs got=%h want=%h", seg_bus, {6{7'b1000000}});
      end
      checks++;
      if (alarm_ring !== 1'b0) begin
         failures++;
         $display("FAIL reset_ring got=%b want=0", alarm_ring);
      end
      checks++;
      if (tick_1hz !== 1'b0) begin
         failures++;
         $display("FAIL reset_tick got=%b want=0", tick_1hz);
      end
   endtask

   task automatic test_run24();
      int ticks, last;
      do_reset();
      sw_states = 3'b000;
      ticks = 0;
      last  = -1;
      for (int i = 0; i < 2000 && ticks < 400; i++) begin
         cyc();
         checks++;
         if (tick_1hz !== m_tick || seg_bus !== m_seg) begin
            failures++;
            $display("FAIL run24_cycle tick=%b/%b segs=%h want=%h", tick_1hz, m_tick, seg_bus, m_seg);
         end
         if (tick_1hz === 1'b1) begin
            if (last >= 0) begin
               checks++;
               if (i - last != TICK_DIV) begin
                  failures++;
                  $display("FAIL run24_period got=%0d want=%0d", i - last, TICK_DIV);
               end
            end
            last = i;
            ticks++;
         end
      end
      checks++;
      if (ticks != 400 || seg_bus !== disp(0, 6, 40, 1'b0)) begin
         failures++;
         $display("FAIL run24_400 ticks=%0d segs=%h want=%h", ticks, seg_bus, disp(0, 6, 40, 1'b0));
      end
   endtask

   task automatic test_edit_time();
      int ticks;
      set_time(23, 59);
      checks++;
      if (seg_bus !== disp(23, 59, 0, 1'b0)) begin
         failures++;
         $display("FAIL edit_set got=%h want=%h", seg_bus, disp(23, 59, 0, 1'b0));
      end
      sw_states[1:0] = 2'b00;
      ticks = 0;
      for (int n = 0; n < 400 && ticks < 60; n++) begin
         cyc();
         if (tick_1hz === 1'b1) begin
            ticks++;
            if (ticks == 58) begin
               checks++;
               if (seg_bus !== disp(23, 59, 58, 1'b0)) begin
                  failures++;
                  $display("FAIL edit_235958 got=%h want=%h", seg_bus, disp(23, 59, 58, 1'b0));
               end
            end
         end
      end
      checks++;
      if (ticks != 60 || seg_bus !== disp(0, 0, 0, 1'b0)) begin
         failures++;
         $display("FAIL edit_rollover ticks=%0d got=%h want=%h", ticks, seg_bus, disp(0, 0, 0, 1'b0));
      end
      set_time(23, 17);
      press(0);
      press(1);
      checks++;
      if (seg_bus !== disp(0, 17, 0, 1'b0)) begin
         failures++;
         $display("FAIL edit_hour_wrap got=%h want=%h", seg_bus, disp(0, 17, 0, 1'b0));
      end
   endtask

   task automatic test_alarm();
      bit ok;
      int ticks;
      do_reset();
      set_alarm(0, 0, 1);
      cyc();
      checks++;
      if (seg_bus !== disp(0, 1, 0, 1'b0)) begin
         failures++;
         $display("FAIL alarm_show got=%h want=%h", seg_bus, disp(0, 1, 0, 1'b0));
      end
      set_time(0, 0);
      sw_states = 3'b100;
      wait_ring("alarm", ok);
      checks++;
      if (seg_bus !== disp(0, 1, 0, 1'b0) || tick_1hz !== 1'b1) begin
         failures++;
         $display("FAIL alarm_rise segs=%h want=%h tick=%b want=1", seg_bus, disp(0, 1, 0, 1'b0), tick_1hz);
      end
      ticks = 0;
      for (int n = 0; n < 200 && alarm_ring === 1'b1; n++) begin
         cyc();
         if (tick_1hz === 1'b1) ticks++;
      end
      checks++;
      if (ticks != RING_S || alarm_ring !== 1'b0) begin
         failures++;
         $display("FAIL alarm_duration got=%0d ticks ring=%b want=%0d ticks ring=0", ticks, alarm_ring, RING_S);
      end
   endtask

   task automatic test_cancel();
      bit ok;
      set_time(0, 0);
      sw_states = 3'b100;
      wait_ring("cancel", ok);
      btn_edit[1] = 1'b1;
      cyc();
      btn_edit = 2'b00;
      checks++;
      if (alarm_ring !== 1'b0) begin
         failures++;
         $display("FAIL cancel_btn got=%b want=0", alarm_ring);
      end
      cyc();
      checks++;
      if (seg_bus !== m_seg || alarm_ring !== 1'b0) begin
         failures++;
         $display("FAIL cancel_time segs=%h want=%h ring=%b", seg_bus, m_seg, alarm_ring);
      end
   endtask

   task automatic test_12h();
      set_time(0, 0);
      sw_states[1:0] = 2'b11;
      cyc();
      checks++;
      if (seg_bus !== disp(12, 0, 0, 1'b0)) begin
         failures++;
         $display("FAIL h12_midnight got=%h want=%h", seg_bus, disp(12, 0, 0, 1'b0));
      end
      set_time(13, 5);
      sw_states[1:0] = 2'b11;
      cyc();
      checks++;
      if (led_hour_tens !== 7'b1111111 || led_hour_units !== 7'b1111001 ||
          led_minutes_units !== 7'b0010010) begin
         failures++;
         $display("FAIL h12_1305 got=%h want=%h", seg_bus, disp(13, 5, 0, 1'b1));
      end
   endtask

   task automatic test_multi_alarm();
      bit ok;
      do_reset();
      set_alarm(3, 7, 30);
      for (int i = 0; i < 3; i++) begin
         alarm_sel = 2'(i);
         cyc();
         checks++;
         if (seg_bus !== disp(0, 0, 0, 1'b0)) begin
            failures++;
            $display("FAIL multi_other%0d got=%h want=%h", i, seg_bus, disp(0, 0, 0, 1'b0));
         end
      end
      set_time(7, 29);
      sw_states = 3'b100;
      wait_ring("multi", ok);
      checks++;
      if (seg_bus !== disp(7, 30, 0, 1'b0)) begin
         failures++;
         $display("FAIL multi_match got=%h want=%h", seg_bus, disp(7, 30, 0, 1'b0));
      end
      sw_states[1:0] = 2'b10;
      alarm_sel = 2'd3;
      cyc();
      btn_edit[1] = 1'b1;
      for (int n = 0; n < 10; n++) cyc();
      btn_edit = 2'b00;
      cyc();
      checks++;
      if (seg_bus !== disp(8, 30, 0, 1'b0) || alarm_ring !== 1'b0) begin
         failures++;
         $display("FAIL multi_held got=%h ring=%b want=%h ring=0", seg_bus, alarm_ring, disp(8, 30, 0, 1'b0));
      end
   endtask

   task automatic test_random();
      sw_states = 3'b100;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) sw_states[1:0] = 2'($urandom);
         if ($urandom_range(0, 99) == 0) sw_states[2] = ~sw_states[2];
         if ($urandom_range(0, 19) == 0) alarm_sel = 2'($urandom);
         btn_edit = ($urandom_range(0, 3) == 0) ? 2'($urandom) : btn_edit;
         if ($urandom_range(0, 799) == 0) do_reset();
         else cyc();
         checks++;
         if (seg_bus !== m_seg || tick_1hz !== m_tick || alarm_ring !== m_ring) begin
            failures++;
            $display("FAIL random_cycle%0d segs=%h want=%h tick=%b/%b ring=%b/%b",
                     n, seg_bus, m_seg, tick_1hz, m_tick, alarm_ring, m_ring);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      sw_states = 3'b000;
      btn_edit  = 2'b00;
      alarm_sel = 2'd0;
      test_reset();
      test_run24();
      test_edit_time();
      test_alarm();
      test_cancel();
      test_12h();
      test_multi_alarm();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
